fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues word-aligned fetches under a two-slot
// credit limit, tracks in-flight PCs, and queues returned instructions for decode.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] pc_branch_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_START = RESET_PC & PC_MASK;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [1:0]      outstanding, outstanding_next;
    logic [1:0]      discard, discard_next;

    logic [XLEN-1:0] inflight_pc [2];
    logic            inflight_wr, inflight_rd;

    logic [XLEN-1:0] fifo_pc    [2];
    logic [31:0]     fifo_instr [2];
    logic            fifo_wr, fifo_rd;
    logic [1:0]      fifo_cnt;

    logic            grant, redirect, rsp, rsp_keep, rsp_drop;
    logic            fifo_push, fifo_pop;
    logic [2:0]      credit_used;

    assign grant       = imem_req_o & imem_gnt_i;
    assign redirect    = branch_taken_i;
    assign rsp         = imem_rvalid_i & (outstanding != 2'd0);
    assign rsp_keep    = rsp & (discard == 2'd0);
    assign rsp_drop    = rsp & (discard != 2'd0);
    assign fifo_push   = rsp_keep & ~redirect;
    assign fifo_pop    = if_valid_o & if_ready_i & ~redirect;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt};

    always_comb begin
        outstanding_next = outstanding;
        case ({grant, rsp})
            2'b10:   outstanding_next = outstanding + 2'd1;
            2'b01:   outstanding_next = outstanding - 2'd1;
            default: outstanding_next = outstanding;
        endcase
    end

    // Every request still outstanding after a redirect edge belongs to the old path.
    always_comb begin
        discard_next = discard;
        if (redirect)
            discard_next = outstanding_next;
        else if (rsp_drop)
            discard_next = discard - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (redirect && discard_next != 2'd0) state_next = DRAIN;
            DRAIN:   if (discard_next == 2'd0) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o = (state == FETCH) && (credit_used < 3'd2);
    end

    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= PC_START;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect)
                fetch_pc <= pc_branch_i & PC_MASK;
            else if (grant)
                fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_pc[0] <= '0;
            inflight_pc[1] <= '0;
            inflight_wr    <= 1'b0;
            inflight_rd    <= 1'b0;
            fifo_pc[0]     <= '0;
            fifo_pc[1]     <= '0;
            fifo_instr[0]  <= '0;
            fifo_instr[1]  <= '0;
            fifo_wr        <= 1'b0;
            fifo_rd        <= 1'b0;
            fifo_cnt       <= '0;
        end else if (redirect) begin
            inflight_wr <= 1'b0;
            inflight_rd <= 1'b0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (grant) begin
                inflight_pc[inflight_wr] <= fetch_pc;
                inflight_wr              <= ~inflight_wr;
            end
            if (rsp_keep)
                inflight_rd <= ~inflight_rd;
            if (fifo_push) begin
                fifo_pc[fifo_wr]    <= inflight_pc[inflight_rd];
                fifo_instr[fifo_wr] <= imem_rdata_i;
                fifo_wr             <= ~fifo_wr;
            end
            if (fifo_pop)
                fifo_rd <= ~fifo_rd;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign if_valid_o = (fifo_cnt != 2'd0);
    assign if_pc_o    = if_valid_o ? fifo_pc[fifo_rd]    : '0;
    assign if_instr_o = if_valid_o ? fifo_instr[fifo_rd] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model tags responses as live or stale,
// live ones are queued as expected decode transfers and compared in order.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, branch_taken, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;
    logic [31:0] pc_branch, imem_addr, imem_rdata, if_pc, if_instr;

    logic        rst_w, req_w, gnt_w, rvalid_w, valid_w;
    logic [31:0] addr_w, rdata_w, pc_w, instr_w;

    fetch_unit u_dut (
        .clk_i(clk), .rst_i(rst), .branch_taken_i(branch_taken), .pc_branch_i(pc_branch),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .if_valid_o(if_valid), .if_ready_i(if_ready), .if_pc_o(if_pc), .if_instr_o(if_instr)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst_w), .branch_taken_i(1'b0), .pc_branch_i(32'h0),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(gnt_w),
        .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
        .if_valid_o(valid_w), .if_ready_i(1'b1), .if_pc_o(pc_w), .if_instr_o(instr_w)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; bit stale; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    rsp_t        pend[$];
    exp_t        sb[$];
    logic [31:0] model_pc;
    int unsigned n_cmp = 0, n_bad = 0, n_xfer = 0;
    bit          xfer_seen;
    logic [31:0] xfer_pc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // One cycle, called at a falling edge: retire a transfer, return a response, offer a grant.
    task automatic step(input bit b, input logic [31:0] tgt, input bit g, input bit r, input bit rv);
        exp_t e;
        rsp_t p;
        xfer_seen = 1'b0;
        check("if_valid", 32'(if_valid), 32'(sb.size() != 0));
        branch_taken = b;
        pc_branch    = tgt;
        if_ready     = r;
        if (if_valid && r && !b && sb.size() != 0) begin
            e = sb.pop_front();
            check("if_pc", if_pc, e.pc);
            check("if_instr", if_instr, e.instr);
            xfer_seen = 1'b1;
            xfer_pc   = if_pc;
            n_xfer++;
        end
        if (rv && pend.size() != 0) begin
            p           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = p.data;
            if (!p.stale && !b)
                sb.push_back('{pc: p.addr, instr: p.data});
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = g;
        if (imem_req && g) begin
            check("imem_addr", imem_addr, model_pc);
            pend.push_back('{addr: model_pc, data: $urandom, stale: b});
            model_pc += 32'd4;
        end
        if (b) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            sb.delete();
            model_pc = {tgt[31:2], 2'b00};
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        branch_taken = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        if_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pend.delete();
        sb.delete();
        model_pc = 32'h0;
        rst      = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wexp [3];
        int unsigned got;
        bit          prev_grant;
        int unsigned x0;

        rst = 1'b1; branch_taken = 1'b0; pc_branch = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        rst_w = 1'b1; gnt_w = 1'b0; rvalid_w = 1'b0; rdata_w = '0;
        model_pc = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);

        // Free-running stream
        rst = 1'b0;
        check("idle_req", 32'(imem_req), 32'h0);
        step(0, 0, 1, 1, 1);
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);
        x0 = n_xfer;
        repeat (12) step(0, 0, 1, 1, 1);
        check("run_xfers", 32'(n_xfer - x0 >= 3), 32'h1);

        // Decode stall fills the FIFO and throttles requests
        do_reset();
        repeat (6) step(0, 0, 1, 0, 1);
        check("stall_req", 32'(imem_req), 32'h0);
        check("stall_valid", 32'(if_valid), 32'h1);
        check("stall_head", if_pc, 32'h0);
        step(0, 0, 1, 1, 1);
        check("stall_release_pc", xfer_pc, 32'h0);
        repeat (10) step(0, 0, 1, 1, 1);

        // Redirect with two outstanding requests
        do_reset();
        repeat (4) step(0, 0, 1, 1, 0);
        check("two_out_req", 32'(imem_req), 32'h0);
        step(1, 32'h0000_0103, 1, 1, 0);
        check("drain_req", 32'(imem_req), 32'h0);
        for (int i = 0; i < 10 && !imem_req; i++) step(0, 0, 0, 1, 1);
        check("redir_req", 32'(imem_req), 32'h1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        xfer_seen = 1'b0;
        for (int i = 0; i < 12 && !xfer_seen; i++) step(0, 0, 1, 1, 1);
        check("redir_first_pc", xfer_pc, 32'h0000_0100);

        // Redirect coinciding with grant and response
        do_reset();
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        check("same_req", 32'(imem_req), 32'h1);
        step(1, 32'h0000_0200, 1, 1, 1);
        check("flush_empty", 32'(if_valid), 32'h0);
        xfer_seen = 1'b0;
        for (int i = 0; i < 12 && !xfer_seen; i++) step(0, 0, 1, 1, 1);
        check("same_first_pc", xfer_pc, 32'h0000_0200);

        // Asynchronous reset mid-stream
        do_reset();
        repeat (4) step(0, 0, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(imem_req), 32'h0);
        check("rst_mid_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        pend.delete();
        sb.delete();
        model_pc = 32'h0;
        imem_rvalid = 1'b0;
        rst = 1'b0;
        check("rst_rel_req", 32'(imem_req), 32'h0);
        step(0, 0, 1, 1, 1);
        check("rst_rel_addr", imem_addr, 32'h0);
        repeat (6) step(0, 0, 1, 1, 1);

        // Random traffic with occasional redirects
        do_reset();
        repeat (300)
            step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        repeat (12) step(0, 0, 0, 1, 1);

        // PC wrap at the top of the address space
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        got = 0;
        prev_grant = 1'b0;
        rst_w = 1'b0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            rvalid_w   = prev_grant;
            rdata_w    = $urandom;
            gnt_w      = 1'b1;
            prev_grant = req_w;
            if (req_w) begin
                check($sformatf("wrap_addr%0d", got), addr_w, wexp[got]);
                got++;
            end
            @(negedge clk);
        end
        check("wrap_count", got, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
